// File: rtl/risc_v_mike_instruction_memory_sram.sv
// ---------------------------------------------------------------------------
// risc_v_mike_instruction_memory_sram
// Writable instruction memory for the RISC-V Mike core. After reset, or on
// i_clear_req, a sequential engine zeroes every word (one word per cycle).
// Once READY, words are loaded through the program port and read through a
// request/response fetch handshake. The read is registered (latency 1) and
// honours backpressure. Misaligned and out-of-range fetches return NOP_WORD
// with an error code instead of reading the array.
//
// Ports
//   i_clk, i_rst          clock, async active-high reset
//   i_clear_req           pulse: restart the clear engine (READY only)
//   o_init_done           high only in READY
//   i_prog_we/addr/wdata  program write (word index)
//   o_prog_err            pulse: a program write was dropped
//   i_fetch_req_valid     fetch request valid
//   o_fetch_req_ready     fetch request accepted this cycle
//   i_fetch_addr          byte PC
//   o_fetch_resp_valid    response valid
//   i_fetch_resp_ready    consumer takes the response
//   o_fetch_rdata         instruction word
//   o_fetch_err           response is an error
//   o_fetch_err_code      00 ok, 01 misaligned, 10 out of range
// ---------------------------------------------------------------------------
module risc_v_mike_instruction_memory_sram #(
  parameter int                 DATA_W    = 32,
  parameter int                 DEPTH     = 1024,
  parameter logic [31:0]        TEXT_BASE = 32'h0040_0000,
  parameter logic [DATA_W-1:0]  NOP_WORD  = DATA_W'(32'h0000_0013),
  localparam int                AW        = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear_req,
  output logic              o_init_done,
  input  logic              i_prog_we,
  input  logic [AW-1:0]     i_prog_addr,
  input  logic [DATA_W-1:0] i_prog_wdata,
  output logic              o_prog_err,
  input  logic              i_fetch_req_valid,
  output logic              o_fetch_req_ready,
  input  logic [31:0]       i_fetch_addr,
  output logic              o_fetch_resp_valid,
  input  logic              i_fetch_resp_ready,
  output logic [DATA_W-1:0] o_fetch_rdata,
  output logic              o_fetch_err,
  output logic [1:0]        o_fetch_err_code
);

  localparam logic [31:0]   DEPTH_L = 32'(DEPTH);
  localparam logic [AW-1:0] LAST_W  = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_prog_err;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic              w_ready_st;
  logic              w_clear_go;
  logic              w_prog_ok;
  logic              w_req_ready;
  logic              w_accept;
  logic [31:0]       w_off;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic [AW-1:0]     w_idx;

  assign w_ready_st = (r_state == ST_READY);
  assign w_clear_go = w_ready_st && i_clear_req;
  // A clear request in the same cycle wins over a program write.
  assign w_prog_ok  = w_ready_st && i_prog_we && !i_clear_req;

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_CLEAR;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_cnt == LAST_W) w_state_nxt = ST_READY;
      ST_READY: if (i_clear_req)         w_state_nxt = ST_CLEAR;
      default:                           w_state_nxt = ST_CLEAR;
    endcase
  end

  // Clear counter wraps to 0 after the last word, so it is already 0 when
  // READY is entered; a clear request re-zeroes it explicitly anyway.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   r_clr_cnt <= '0;
    else if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
    else if (w_clear_go)         r_clr_cnt <= '0;
  end

  // Array write port: clear engine or program port (no reset on contents).
  always_ff @(posedge i_clk) begin
    if (r_state == ST_CLEAR) r_mem[r_clr_cnt]   <= '0;
    else if (w_prog_ok)      r_mem[i_prog_addr] <= i_prog_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prog_err <= 1'b0;
    else       r_prog_err <= i_prog_we && !w_prog_ok;
  end

  // Fetch decode. TEXT_BASE is word aligned, so off[1:0] is the PC's
  // alignment; the range check uses the wrapped offset plus a lower bound.
  assign w_off          = i_fetch_addr - TEXT_BASE;
  assign w_misaligned   = (w_off[1:0] != 2'b00);
  assign w_out_of_range = (i_fetch_addr < TEXT_BASE) ||
                          ({2'b00, w_off[31:2]} >= DEPTH_L);
  assign w_idx          = w_off[AW+1:2];

  assign w_req_ready = w_ready_st && (!r_resp_valid || i_fetch_resp_ready);
  assign w_accept    = i_fetch_req_valid && w_req_ready;

  // Response registers. The array read uses the pre-edge contents, which
  // gives read-before-write against a same-cycle program write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
    end else if (w_clear_go) begin
      r_resp_valid <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      if (w_misaligned) begin
        r_rdata    <= NOP_WORD;
        r_err      <= 1'b1;
        r_err_code <= 2'b01;
      end else if (w_out_of_range) begin
        r_rdata    <= NOP_WORD;
        r_err      <= 1'b1;
        r_err_code <= 2'b10;
      end else begin
        r_rdata    <= r_mem[w_idx];
        r_err      <= 1'b0;
        r_err_code <= 2'b00;
      end
    end else if (i_fetch_resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign o_init_done        = w_ready_st;
  assign o_prog_err         = r_prog_err;
  assign o_fetch_req_ready  = w_req_ready;
  assign o_fetch_resp_valid = r_resp_valid;
  assign o_fetch_rdata      = r_rdata;
  assign o_fetch_err        = r_err;
  assign o_fetch_err_code   = r_err_code;

endmodule

// File: tb/tb_risc_v_mike_instruction_memory_sram.sv
module tb_risc_v_mike_instruction_memory_sram;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, clear_req, prog_we, prog_err, init_done;
  logic [9:0]  prog_addr;
  logic [31:0] prog_wdata;
  logic        req_valid, req_ready, resp_valid, resp_ready, ferr;
  logic [31:0] fetch_addr, rdata;
  logic [1:0]  code;

  always #5 clk = ~clk;

  risc_v_mike_instruction_memory_sram dut (
    .i_clk(clk), .i_rst(rst), .i_clear_req(clear_req), .o_init_done(init_done),
    .i_prog_we(prog_we), .i_prog_addr(prog_addr), .i_prog_wdata(prog_wdata),
    .o_prog_err(prog_err), .i_fetch_req_valid(req_valid),
    .o_fetch_req_ready(req_ready), .i_fetch_addr(fetch_addr),
    .o_fetch_resp_valid(resp_valid), .i_fetch_resp_ready(resp_ready),
    .o_fetch_rdata(rdata), .o_fetch_err(ferr), .o_fetch_err_code(code));

  typedef struct packed {logic [31:0] rdata; logic err; logic [1:0] code;} resp_t;
  typedef struct {logic [31:0] addr; resp_t exp;} vec_t;

  resp_t       sb[$];
  resp_t       pend_exp;
  logic [31:0] m_mem [DEPTH];
  int          n_tests = 0, n_fail = 0;
  // snapshot of the cycle just simulated, taken at the falling edge
  logic        acc, s_ready, s_valid, s_init, s_perr;
  logic [31:0] s_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference decode.
  function automatic resp_t model(input logic [31:0] a);
    resp_t r;
    if (a[1:0] != 2'b00)                          r = '{NOP, 1'b1, 2'b01};
    else if (a < BASE || a >= BASE + DEPTH * 4)   r = '{NOP, 1'b1, 2'b10};
    else                                          r = '{m_mem[(a - BASE) / 4], 1'b0, 2'b00};
    return r;
  endfunction

  // One clock: evaluate handshake at negedge, then advance past posedge.
  task automatic cyc();
    resp_t e;
    @(negedge clk);
    s_ready = req_ready; s_valid = resp_valid; s_init = init_done;
    s_perr = prog_err; s_rdata = rdata;
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) chk("unexpected_resp", {rdata, ferr, code}, 64'hx);
      else begin
        e = sb.pop_front();
        chk("resp", {29'd0, rdata, ferr, code}, {29'd0, e});
      end
    end
    acc = req_valid && req_ready;
    if (acc) sb.push_back(pend_exp);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [31:0] a, input resp_t e);
    req_valid = 1'b1; fetch_addr = a; pend_exp = e;
    for (int t = 0; t < 20; t++) begin
      cyc();
      if (acc) break;
    end
    if (!acc) chk("fetch_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic prog(input int a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = 10'(a); prog_wdata = d;
    cyc();
    prog_we = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic drain();
    for (int t = 0; t < 3; t++) cyc();
    chk("sb_empty", sb.size(), 0);
  endtask

  // Counts cycles from reset release; init/ready must rise at exactly DEPTH.
  task automatic wait_init(input bit poke_prog);
    bit early = 0;
    req_valid = 1'b1; fetch_addr = BASE; pend_exp = '{32'h0, 1'b0, 2'b00};
    for (int j = 0; j <= DEPTH; j++) begin
      prog_we = (poke_prog && j == 10);
      prog_addr = 10'd7; prog_wdata = 32'h1111_2222;
      cyc();
      if (j < DEPTH && (s_init || s_ready)) early = 1;
      if (poke_prog && j == 11) chk("prog_err_in_clear", s_perr, 1);
      if (j == DEPTH) begin
        chk("init_done_at_depth", {s_init, s_ready, acc}, 3'b111);
      end
    end
    prog_we = 1'b0;
    chk("no_early_ready", early, 0);
    req_valid = 1'b0;
  endtask

  vec_t vecs[$];
  int   prev_acc;

  initial begin
    rst = 1; clear_req = 0; prog_we = 0; prog_addr = 0; prog_wdata = 0;
    req_valid = 0; fetch_addr = 0; resp_ready = 1; pend_exp = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    repeat (3) cyc();
    chk("reset_outputs", {init_done, prog_err, req_ready, resp_valid, rdata, ferr, code},
        {4'b0000, 32'h0, 1'b0, 2'b00});
    rst = 0;
    wait_init(1'b0);
    drain();   // first fetch at BASE returns 0, ok

    prog(0, 32'h0fc10417); prog(1, 32'h02440493);
    prog(2, 32'h02840913); prog(3, 32'h00092a83);

    vecs.push_back('{BASE + 0,      '{32'h0fc10417, 1'b0, 2'b00}});
    vecs.push_back('{BASE + 4,      '{32'h02440493, 1'b0, 2'b00}});
    vecs.push_back('{BASE + 8,      '{32'h02840913, 1'b0, 2'b00}});
    vecs.push_back('{BASE + 12,     '{32'h00092a83, 1'b0, 2'b00}});
    vecs.push_back('{32'h0040_0006, '{NOP, 1'b1, 2'b01}});
    vecs.push_back('{32'h0040_1000, '{NOP, 1'b1, 2'b10}});
    vecs.push_back('{32'h003F_FFFC, '{NOP, 1'b1, 2'b10}});
    vecs.push_back('{32'h0040_0FFC, '{32'h0, 1'b0, 2'b00}});
    vecs.push_back('{32'h003F_FFFE, '{NOP, 1'b1, 2'b01}});
    vecs.push_back('{32'hFFFF_FFFC, '{NOP, 1'b1, 2'b10}});

    // back-to-back, valid held: every cycle must accept, response 1 cycle later
    prev_acc = 0;
    req_valid = 1'b1;
    foreach (vecs[i]) begin
      fetch_addr = vecs[i].addr; pend_exp = vecs[i].exp;
      cyc();
      chk("b2b_accept", acc, 1);
      if (prev_acc != 0) chk("latency1", s_valid, 1);
      prev_acc = acc;
    end
    req_valid = 1'b0;
    drain();

    // backpressure
    fetch(BASE + 4, model(BASE + 4));
    resp_ready = 1'b0; req_valid = 1'b1; fetch_addr = BASE + 8; pend_exp = model(BASE + 8);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_hold", {s_valid, s_ready, acc, s_rdata}, {3'b100, 32'h02440493});
    end
    resp_ready = 1'b1;
    cyc();
    chk("bp_release_accept", {s_ready, acc}, 2'b11);
    req_valid = 1'b0;
    drain();

    // same-cycle fetch + program to word 2: old data, then new
    req_valid = 1'b1; fetch_addr = BASE + 8; pend_exp = model(BASE + 8);
    prog_we = 1'b1; prog_addr = 10'd2; prog_wdata = 32'hDEADBEEF;
    cyc();
    chk("rbw_accept", acc, 1);
    prog_we = 1'b0; m_mem[2] = 32'hDEADBEEF;
    pend_exp = model(BASE + 8);
    cyc();
    req_valid = 1'b0;
    drain();

    // pending response, then clear_req with prog_we; rst mid-clear
    resp_ready = 1'b0;
    fetch(BASE, model(BASE));
    clear_req = 1'b1; prog_we = 1'b1; prog_addr = 10'd5; prog_wdata = 32'h1234_5678;
    cyc();
    clear_req = 1'b0; prog_we = 1'b0;
    sb.delete();
    cyc();
    chk("clear_drop_perr", {s_valid, s_init, s_perr}, 3'b001);
    cyc();
    chk("perr_once", s_perr, 0);
    resp_ready = 1'b1;
    repeat (100) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    wait_init(1'b1);
    drain();
    fetch(BASE + 0,  model(BASE + 0));
    fetch(BASE + 8,  model(BASE + 8));
    fetch(BASE + 12, model(BASE + 12));
    fetch(BASE + 20, model(BASE + 20));
    fetch(BASE + 28, model(BASE + 28));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/risc_v_mike_instruction_memory_sram.md
Name: risc_v_mike_instruction_memory_sram

Overview:
- Parametrised, writable instruction memory for the RISC-V Mike core; replaces the fixed, combinationally read instruction table.
- Word array loaded at run time through a program port; read via a request/response fetch handshake with a registered, 1-cycle read and backpressure.
- Clears itself after reset, and on request, with a sequential clear engine.
- Reports misaligned and out-of-range fetches as error responses instead of returning garbage.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 1024, number of words; power of two, >= 2.
- TEXT_BASE, 32'h0040_0000, byte address of word 0 (text segment lower limit).
- NOP_WORD, 32'h0000_0013, data returned on an error response.
- AW, $clog2(DEPTH), derived word-index width; not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- clear_req  input  1  pulse; starts a full clear when in READY.
- init_done  output  1  high only in READY.
- prog_we  input  1  program write strobe.
- prog_addr  input  AW  word index to write.
- prog_wdata  input  DATA_W  word to write.
- prog_err  output  1  1-cycle pulse when prog_we is dropped.
- fetch_req_valid  input  1  fetch request valid.
- fetch_req_ready  output  1  fetch request accepted this cycle.
- fetch_addr  input  32  byte PC (t_pc_addr).
- fetch_resp_valid  output  1  response valid.
- fetch_resp_ready  input  1  consumer accepts the response.
- fetch_rdata  output  DATA_W  instruction word.
- fetch_err  output  1  response is an error.
- fetch_err_code  output  2  00 ok, 01 misaligned, 10 out of range.

Behaviour:
- Reset (asynchronous, active-high):
  - state = CLEAR, clear counter = 0.
  - init_done = 0, prog_err = 0, fetch_req_ready = 0, fetch_resp_valid = 0.
  - fetch_rdata = 0, fetch_err = 0, fetch_err_code = 00.
  - Array contents are not reset directly; the CLEAR state handles them.
- State machine:
  - CLEAR: each cycle writes 0 to word[counter], then counter++. After writing word DEPTH-1, next state is READY. Duration is exactly DEPTH cycles.
  - READY: normal operation. clear_req in READY moves to CLEAR next cycle with counter = 0; a pending response is dropped (resp_valid = 0).
  - rst asserted mid-CLEAR or mid-READY restarts CLEAR from word 0.
- Program port:
  - A write lands at the clock edge when prog_we = 1 and state = READY.
  - prog_we in CLEAR is dropped and prog_err pulses for 1 cycle.
  - prog_we in the same cycle as clear_req: the clear wins, the write is dropped, and prog_err pulses.
- Fetch handshake:
  - fetch_req_ready = (state == READY) && (!fetch_resp_valid || fetch_resp_ready).
  - A request is accepted when valid && ready. The response registers appear the next cycle (latency 1).
  - Full throughput: 1 fetch per cycle while fetch_resp_ready = 1.
  - While fetch_resp_valid = 1 and fetch_resp_ready = 0, all response outputs hold stable and no new request is accepted.
  - If nothing is accepted in a cycle where the response is consumed, fetch_resp_valid drops to 0.
- Address decode, 32-bit unsigned arithmetic:
  - off = fetch_addr - TEXT_BASE, wrapping modulo 2^32.
  - Misaligned when off[1:0] != 0; code 01. This check has priority.
  - Out of range when fetch_addr < TEXT_BASE or (off >> 2) >= DEPTH; code 10.
  - On error: fetch_rdata = NOP_WORD, fetch_err = 1, and the array is not read.
  - Otherwise: fetch_rdata = word[off >> 2], fetch_err = 0, code 00.
- Fetch and program write to the same word in the same cycle: the fetch returns the old data (read-before-write). A fetch one cycle later sees the new data.
- No combinational path from fetch_addr to fetch_rdata.

Test Plan:
- Reset, then hold fetch_req_valid = 1 -> init_done rises exactly DEPTH cycles after reset release; fetch_req_ready stays 0 until then. The first fetch at 32'h0040_0000 returns 32'h0000_0000, err = 0.
- Program words 0..3 = 0fc10417, 02440493, 02840913, 00092a83; then back-to-back fetches 0x00400000, 0x00400004, 0x00400008, 0x0040000C with resp_ready = 1 -> the four words return on four consecutive cycles, each 1 cycle after acceptance.
- Fetch 0x00400006 -> rdata = 0000_0013, err = 1, code 01. Fetch 0x0040_1000 with DEPTH = 1024 -> code 10. Fetch 0x003F_FFFC -> code 10.
- Backpressure: accept fetch 0x00400004, then hold resp_ready = 0 for 3 cycles -> outputs hold 02440493, fetch_req_ready = 0. Release -> the next request is accepted in that same cycle.
- Same-cycle fetch and prog_we to word 2 with new data DEADBEEF -> response is 02840913; the following fetch of word 2 returns DEADBEEF.
- clear_req together with prog_we, then rst pulsed mid-clear -> prog_err pulses once, clear restarts at word 0, init_done returns after DEPTH cycles, and all previously programmed words read 0.
